// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read bus: single-outstanding req/ack handshake.
// master = fetch unit side, slave = instruction memory side.
interface instr_fetch_unit_if #(
   parameter int ADDR_W = 32
);
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_ack;
   logic [31:0]       imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: fetch PC, one-outstanding imem handshake,
// DEPTH-entry instruction buffer and decode-field split for the control unit.
// Optional feature macro: FETCH_COUNT_EN adds pop (fetch_cnt) and redirect
// (flush_cnt) counters as extra output ports.
module instr_fetch_unit #(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int                DEPTH    = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   instr_fetch_unit_if.master   imem_bus,
   input  logic                 PCSrc,
   input  logic [ADDR_W-1:0]    branch_target,
   input  logic                 stall,
   output logic                 instr_valid,
   output logic [31:0]          Instr,
   output logic [ADDR_W-1:0]    PC,
   output logic [ADDR_W-1:0]    PCPlus8,
   output logic [3:0]           Cond,
   output logic [1:0]           Op,
   output logic [5:0]           Funct,
   output logic [3:0]           Rd
`ifdef FETCH_COUNT_EN
   ,
   output logic [31:0]          fetch_cnt,
   output logic [15:0]          flush_cnt
`endif
);

   localparam int                PTR_W   = $clog2(DEPTH);
   localparam int                CNT_W   = PTR_W + 1;
   localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      FLUSH = 2'd2
   } state_t;

   state_t            state;
   logic              req_q;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] fpc;
   logic [ADDR_W-1:0] fpc_inc;
   logic [ADDR_W-1:0] target;

   logic [31:0]       buf_instr [DEPTH];
   logic [ADDR_W-1:0] buf_addr  [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic [CNT_W-1:0]  count_next;

   logic              ack;
   logic              push;
   logic              pop;
   logic              unused_tgt_bits;

   assign imem_bus.imem_req  = req_q;
   assign imem_bus.imem_addr = addr_q;

   assign ack     = imem_bus.imem_ack && req_q;
   assign push    = ack && (state == REQ) && !PCSrc;
   assign pop     = instr_valid && !stall && !PCSrc;
   assign fpc_inc = fpc + ADDR_W'(4);
   assign target  = {branch_target[ADDR_W-1:2], 2'b00};
   assign unused_tgt_bits = ^branch_target[1:0];

   // Buffer occupancy after this edge; a redirect empties the buffer.
   always_comb begin
      count_next = count;
      if (PCSrc)
         count_next = '0;
      else if (push && !pop)
         count_next = count + CNT_W'(1);
      else if (!push && pop)
         count_next = count - CNT_W'(1);
   end

   // Fetch FSM: owns fetch PC and the registered imem request/address.
   // In FLUSH the old address stays on the bus while fpc already holds the
   // redirect target, so the dropped response cannot disturb the new stream.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         req_q  <= 1'b0;
         addr_q <= RESET_PC;
         fpc    <= RESET_PC;
      end else if (PCSrc) begin
         fpc <= target;
         if (state == IDLE || ack) begin
            state  <= REQ;
            req_q  <= 1'b1;
            addr_q <= target;
         end else begin
            state <= FLUSH;
         end
      end else begin
         case (state)
            IDLE: begin
               if (count_next < DEPTH_C) begin
                  state  <= REQ;
                  req_q  <= 1'b1;
                  addr_q <= fpc;
               end
            end
            REQ: begin
               if (ack) begin
                  fpc <= fpc_inc;
                  if (count_next < DEPTH_C) begin
                     addr_q <= fpc_inc;
                  end else begin
                     state <= IDLE;
                     req_q <= 1'b0;
                  end
               end
            end
            FLUSH: begin
               if (ack) begin
                  state  <= REQ;
                  addr_q <= fpc;
               end
            end
            default: begin
               state <= IDLE;
               req_q <= 1'b0;
            end
         endcase
      end
   end

   // Buffer pointers and occupancy.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (PCSrc) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count_next;
      end
   end

   // Buffer storage; contents are only observed through valid entries.
   always_ff @(posedge clk) begin
      if (push) begin
         buf_instr[wr_ptr] <= imem_bus.imem_rdata;
         buf_addr[wr_ptr]  <= addr_q;
      end
   end

   // Head entry presentation, zeroed when the buffer is empty.
   always_comb begin
      instr_valid = (count != '0);
      Instr       = instr_valid ? buf_instr[rd_ptr] : '0;
      PC          = instr_valid ? buf_addr[rd_ptr]  : '0;
      PCPlus8     = instr_valid ? buf_addr[rd_ptr] + ADDR_W'(8) : '0;
      Cond        = Instr[31:28];
      Op          = Instr[27:26];
      Funct       = Instr[25:20];
      Rd          = Instr[15:12];
   end

`ifdef FETCH_COUNT_EN
   // Free-running wrap-around counters of pops and redirects.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (pop)
            fetch_cnt <= fetch_cnt + 32'd1;
         if (PCSrc)
            flush_cnt <= flush_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: reset, zero-wait streaming, stall
// back-pressure, redirect with in-flight request, redirect with same-cycle
// ack, and asynchronous reset mid-request.
module tb_instr_fetch_unit;

   logic        clk;
   logic        rst;
   logic        PCSrc;
   logic [31:0] branch_target;
   logic        stall;
   logic        instr_valid;
   logic [31:0] Instr;
   logic [31:0] PC;
   logic [31:0] PCPlus8;
   logic [3:0]  Cond;
   logic [1:0]  Op;
   logic [5:0]  Funct;
   logic [3:0]  Rd;
`ifdef FETCH_COUNT_EN
   logic [31:0] fetch_cnt;
   logic [15:0] flush_cnt;
`endif

   int unsigned vectors;
   int unsigned miscompares;

   instr_fetch_unit_if #(.ADDR_W(32)) imem_bus ();

   instr_fetch_unit #(
      .ADDR_W   (32),
      .RESET_PC (32'h0),
      .DEPTH    (2)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .imem_bus      (imem_bus.master),
      .PCSrc         (PCSrc),
      .branch_target (branch_target),
      .stall         (stall),
      .instr_valid   (instr_valid),
      .Instr         (Instr),
      .PC            (PC),
      .PCPlus8       (PCPlus8),
      .Cond          (Cond),
      .Op            (Op),
      .Funct         (Funct),
      .Rd            (Rd)
`ifdef FETCH_COUNT_EN
      ,
      .fetch_cnt     (fetch_cnt),
      .flush_cnt     (flush_cnt)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Instruction memory image: fixed word at 0, address-tagged elsewhere.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a == 32'h0) ? 32'hE0810002 : (32'hE0000000 | a);
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Zero-wait memory: acknowledge whatever is requested this cycle.
   task automatic mem_zw();
      imem_bus.imem_ack   = imem_bus.imem_req;
      imem_bus.imem_rdata = imem_bus.imem_req ? mem_word(imem_bus.imem_addr) : 32'h0;
   endtask

   task automatic mem_idle();
      imem_bus.imem_ack   = 1'b0;
      imem_bus.imem_rdata = 32'h0;
   endtask

   initial begin
      vectors       = 0;
      miscompares   = 0;
      rst           = 1'b0;
      PCSrc         = 1'b0;
      branch_target = 32'h0;
      stall         = 1'b0;
      mem_idle();

      // Reset held for 3 cycles
      repeat (3) @(negedge clk);
      check("rst_req",   32'(imem_bus.imem_req), 32'h0);
      check("rst_addr",  imem_bus.imem_addr, 32'h0);
      check("rst_valid", 32'(instr_valid), 32'h0);
      check("rst_instr", Instr, 32'h0);
      check("rst_pc",    PC, 32'h0);
      check("rst_pc8",   PCPlus8, 32'h0);
      rst = 1'b1;
      @(negedge clk);
      check("first_req",  32'(imem_bus.imem_req), 32'h1);
      check("first_addr", imem_bus.imem_addr, 32'h0);

      // Zero-wait streaming, one instruction per cycle
      mem_zw();
      @(negedge clk);
      check("zw_valid", 32'(instr_valid), 32'h1);
      check("zw_instr", Instr, 32'hE0810002);
      check("zw_cond",  32'(Cond), 32'hE);
      check("zw_op",    32'(Op), 32'h0);
      check("zw_funct", 32'(Funct), 32'h08);
      check("zw_rd",    32'(Rd), 32'h0);
      check("zw_pc8",   PCPlus8, 32'h8);
      for (int i = 0; i < 4; i++) begin
         check("zw_pc",   PC, 32'(4 * i));
         check("zw_addr", imem_bus.imem_addr, 32'(4 * i + 4));
         check("zw_req",  32'(imem_bus.imem_req), 32'h1);
         mem_zw();
         @(negedge clk);
      end

      // Asynchronous reset mid-request, pending ack ignored
      imem_bus.imem_ack = 1'b1;
      rst = 1'b0;
      #1;
      check("arst_req",   32'(imem_bus.imem_req), 32'h0);
      check("arst_addr",  imem_bus.imem_addr, 32'h0);
      check("arst_valid", 32'(instr_valid), 32'h0);
      check("arst_pc",    PC, 32'h0);
      @(negedge clk);
      @(negedge clk);
      check("arst_hold_req", 32'(imem_bus.imem_req), 32'h0);
      rst = 1'b1;
      mem_idle();
      @(negedge clk);
      check("restart_req",  32'(imem_bus.imem_req), 32'h1);
      check("restart_addr", imem_bus.imem_addr, 32'h0);

      // Stall for 6 cycles: buffer fills with 0x0, 0x4 then request stops
      stall = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (i == 5) begin
            check("stall_req",   32'(imem_bus.imem_req), 32'h0);
            check("stall_valid", 32'(instr_valid), 32'h1);
            check("stall_pc",    PC, 32'h0);
         end
         mem_zw();
         if (i < 5)
            @(negedge clk);
      end
      stall = 1'b0;
      @(negedge clk);
      check("unstall_pc",   PC, 32'h4);
      check("unstall_req",  32'(imem_bus.imem_req), 32'h1);
      check("unstall_addr", imem_bus.imem_addr, 32'h8);

      // Redirect with request 0x8 in flight, ack 3 cycles later
      PCSrc         = 1'b1;
      branch_target = 32'h103;
      mem_idle();
      @(negedge clk);
      PCSrc = 1'b0;
      check("fl_valid", 32'(instr_valid), 32'h0);
      check("fl_instr", Instr, 32'h0);
      check("fl_req",   32'(imem_bus.imem_req), 32'h1);
      check("fl_addr",  imem_bus.imem_addr, 32'h8);
      @(negedge clk);
      check("fl_hold_addr", imem_bus.imem_addr, 32'h8);
      @(negedge clk);
      imem_bus.imem_ack   = 1'b1;
      imem_bus.imem_rdata = 32'hDEADBEEF;
      @(negedge clk);
      check("fl_tgt_req",   32'(imem_bus.imem_req), 32'h1);
      check("fl_tgt_addr",  imem_bus.imem_addr, 32'h100);
      check("fl_tgt_valid", 32'(instr_valid), 32'h0);
      mem_zw();
      @(negedge clk);
      check("tgt_valid", 32'(instr_valid), 32'h1);
      check("tgt_pc",    PC, 32'h100);
      check("tgt_instr", Instr, 32'hE0000100);
      check("tgt_pc8",   PCPlus8, 32'h108);
      check("tgt_addr",  imem_bus.imem_addr, 32'h104);

      // Redirect in the same cycle as an ack: no FLUSH
      mem_zw();
      PCSrc         = 1'b1;
      branch_target = 32'h100;
      @(negedge clk);
      PCSrc = 1'b0;
      check("sa_req",   32'(imem_bus.imem_req), 32'h1);
      check("sa_addr",  imem_bus.imem_addr, 32'h100);
      check("sa_valid", 32'(instr_valid), 32'h0);
      mem_zw();
      @(negedge clk);
      check("sa_pc",    PC, 32'h100);
      check("sa_next",  imem_bus.imem_addr, 32'h104);
      mem_idle();
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
